vmmu_write_arbiter: RTL and testbench

Write-side front end for the video memory unit. Arbitrates between two write requesters, such as a CPU bus bridge and a blitter. Accepted address/data pairs are queued in a small FIFO, and the head entry is presented to the memory unit's write slot. An entry is retired only after the memory unit's write slot has completed.

---
 rtl/vmmu_write_arbiter.sv | 144 ++++++++++++++
 tb/tb_vmmu_write_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmmu_write_arbiter.sv
// Write-side front end for the video memory unit: two-requester arbiter feeding a
// small FIFO whose head entry is held stable for the memory unit's write slot.
module vmmu_write_arbiter #(
   parameter int AWIDTH = 19,
   parameter int DWIDTH = 8,
   parameter int DEPTH  = 4
) (
   input  logic                      MemClk,
   input  logic                      MemResetN,
   input  logic                      Req1Valid,
   input  logic [AWIDTH-1:0]         Req1Addr,
   input  logic [DWIDTH-1:0]         Req1Data,
   output logic                      Req1Ready,
   input  logic                      Req2Valid,
   input  logic [AWIDTH-1:0]         Req2Addr,
   input  logic [DWIDTH-1:0]         Req2Data,
   output logic                      Req2Ready,
   output logic [AWIDTH-1:0]         WrAddr,
   output logic [DWIDTH-1:0]         WrData,
   output logic                      HasWriteData,
   input  logic                      WriteDataRdy,
   output logic [$clog2(DEPTH):0]    Level
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [AWIDTH-1:0] addr_mem [DEPTH];
   logic [DWIDTH-1:0] data_mem [DEPTH];

   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              prio_q, prio_d;
   logic              owned_q, owned_d;
   logic              rdy_q;
   logic              has_q, has_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic [DWIDTH-1:0] data_q, data_d;

   logic              not_full;
   logic              grant1;
   logic              grant2;
   logic              push;
   logic              pop;
   logic              load;
   logic [AWIDTH-1:0] push_addr;
   logic [DWIDTH-1:0] push_data;

   // prio_q high means requester 1 wins the next contended cycle.
   always_comb begin
      not_full  = (count_q < FULL_CNT);
      grant1    = Req1Valid && (!Req2Valid || prio_q);
      grant2    = Req2Valid && (!Req1Valid || !prio_q);
      Req1Ready = not_full && grant1;
      Req2Ready = not_full && grant2;
      push      = Req1Ready || Req2Ready;
      push_addr = grant1 ? Req1Addr : Req2Addr;
      push_data = grant1 ? Req1Data : Req2Data;
      pop       = rdy_q && !WriteDataRdy && owned_q;
      load      = !WriteDataRdy && !has_q && (count_q != '0);
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      prio_d   = prio_q;
      owned_d  = owned_q;
      has_d    = has_q;
      addr_d   = addr_q;
      data_d   = data_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (Req1Valid && Req2Valid && not_full) begin
         prio_d = !prio_q;
      end

      // A window is owned only if an entry was already presented when it opened.
      if (!rdy_q && WriteDataRdy) begin
         owned_d = has_q;
      end else if (pop) begin
         owned_d = 1'b0;
      end

      // Pop implies has_q, so load and pop never coincide; address/data hold after pop.
      if (load) begin
         has_d  = 1'b1;
         addr_d = addr_mem[rd_ptr_q];
         data_d = data_mem[rd_ptr_q];
      end else if (pop) begin
         has_d  = 1'b0;
      end
   end

   always_ff @(posedge MemClk or negedge MemResetN) begin
      if (!MemResetN) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         prio_q   <= 1'b1;
         owned_q  <= 1'b0;
         rdy_q    <= 1'b0;
         has_q    <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         prio_q   <= prio_d;
         owned_q  <= owned_d;
         rdy_q    <= WriteDataRdy;
         has_q    <= has_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
      end
   end

   always_ff @(posedge MemClk) begin
      if (push) begin
         addr_mem[wr_ptr_q] <= push_addr;
         data_mem[wr_ptr_q] <= push_data;
      end
   end

   assign WrAddr       = addr_q;
   assign WrData       = data_q;
   assign HasWriteData = has_q;
   assign Level        = count_q;

endmodule

// File: tb/tb_vmmu_write_arbiter.sv
// Directed bench for vmmu_write_arbiter with a queue-based reference model
// checked every cycle, plus hand-computed expectations per scenario.
module tb_vmmu_write_arbiter;

   localparam int AW  = 19;
   localparam int DW  = 8;
   localparam int DEP = 4;

   logic          MemClk = 1'b0;
   logic          MemResetN = 1'b1;
   logic          Req1Valid = 1'b0;
   logic [AW-1:0] Req1Addr = '0;
   logic [DW-1:0] Req1Data = '0;
   logic          Req1Ready;
   logic          Req2Valid = 1'b0;
   logic [AW-1:0] Req2Addr = '0;
   logic [DW-1:0] Req2Data = '0;
   logic          Req2Ready;
   logic [AW-1:0] WrAddr;
   logic [DW-1:0] WrData;
   logic          HasWriteData;
   logic          WriteDataRdy = 1'b0;
   logic [2:0]    Level;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 0;

   vmmu_write_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .DEPTH(DEP)) dut (
      .MemClk(MemClk), .MemResetN(MemResetN),
      .Req1Valid(Req1Valid), .Req1Addr(Req1Addr), .Req1Data(Req1Data), .Req1Ready(Req1Ready),
      .Req2Valid(Req2Valid), .Req2Addr(Req2Addr), .Req2Data(Req2Data), .Req2Ready(Req2Ready),
      .WrAddr(WrAddr), .WrData(WrData), .HasWriteData(HasWriteData),
      .WriteDataRdy(WriteDataRdy), .Level(Level)
   );

   always #5 MemClk = ~MemClk;

   // Reference model: queue of accepted entries plus presented-head bookkeeping.
   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   ent_t          mq[$];
   bit            m_has   = 0;
   logic [AW-1:0] m_addr  = '0;
   logic [DW-1:0] m_data  = '0;
   bit            m_prio1 = 1;
   bit            m_owned = 0;
   bit            m_rdyq  = 0;

   function automatic bit m_r1();
      if (mq.size() >= DEP || !Req1Valid) return 1'b0;
      return !Req2Valid || m_prio1;
   endfunction

   function automatic bit m_r2();
      if (mq.size() >= DEP || !Req2Valid) return 1'b0;
      return !Req1Valid || !m_prio1;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_has = 0; m_addr = '0; m_data = '0;
      m_prio1 = 1; m_owned = 0; m_rdyq = 0;
   endtask

   task automatic model_step();
      bit r1, r2, ret, pres;
      r1   = m_r1();
      r2   = m_r2();
      ret  = m_rdyq && !WriteDataRdy && m_owned;
      pres = !WriteDataRdy && !m_has && (mq.size() > 0);
      if (!m_rdyq && WriteDataRdy) m_owned = m_has;
      else if (ret)                m_owned = 0;
      if (pres) begin
         m_has = 1; m_addr = mq[0].a; m_data = mq[0].d;
      end
      if (ret) begin
         mq.delete(0);
         m_has = 0;
      end
      if (r1) mq.push_back(ent_t'{a: Req1Addr, d: Req1Data});
      if (r2) mq.push_back(ent_t'{a: Req2Addr, d: Req2Data});
      if (Req1Valid && Req2Valid && (r1 || r2)) m_prio1 = !m_prio1;
      m_rdyq = WriteDataRdy;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge MemClk);
         if (cmp_en) begin
            chk("mdl_req1ready", 32'(Req1Ready),    32'(m_r1()));
            chk("mdl_req2ready", 32'(Req2Ready),    32'(m_r2()));
            chk("mdl_has",       32'(HasWriteData), 32'(m_has));
            chk("mdl_wraddr",    32'(WrAddr),       32'(m_addr));
            chk("mdl_wrdata",    32'(WrData),       32'(m_data));
            chk("mdl_level",     32'(Level),        32'(mq.size()));
         end
      end
   end

   task automatic tick();
      @(posedge MemClk);
      if (MemResetN) model_step();
      #1;
   endtask

   task automatic push1(input logic [AW-1:0] a, input logic [DW-1:0] d);
      Req1Valid = 1'b1; Req1Addr = a; Req1Data = d;
      tick();
      Req1Valid = 1'b0;
   endtask

   task automatic retire_one(input logic [DW-1:0] d);
      chk("head_has",  32'(HasWriteData), 32'd1);
      chk("head_data", 32'(WrData),       32'(d));
      WriteDataRdy = 1'b1;
      repeat (3) tick();
      WriteDataRdy = 1'b0;
      chk("prepop_has", 32'(HasWriteData), 32'd1);
      tick();
      chk("pop_has", 32'(HasWriteData), 32'd0);
      tick();
   endtask

   initial begin
      #1 MemResetN = 1'b0;
      model_reset();
      cmp_en = 1;
      #1;
      chk("rst_has",    32'(HasWriteData), 32'd0);
      chk("rst_level",  32'(Level),        32'd0);
      chk("rst_wraddr", 32'(WrAddr),       32'd0);
      chk("rst_wrdata", 32'(WrData),       32'd0);
      chk("rst_ready",  32'({Req1Ready, Req2Ready}), 32'd0);
      #10 MemResetN = 1'b1;
      tick();

      // single write into an empty FIFO
      Req1Valid = 1'b1; Req1Addr = 19'h12345; Req1Data = 8'hA5;
      #1 chk("single_ready", 32'(Req1Ready), 32'd1);
      tick();
      Req1Valid = 1'b0;
      chk("single_level", 32'(Level), 32'd1);
      chk("single_has0",  32'(HasWriteData), 32'd0);
      tick();
      chk("single_has1",  32'(HasWriteData), 32'd1);
      chk("single_addr",  32'(WrAddr), 32'h12345);
      chk("single_data",  32'(WrData), 32'hA5);
      WriteDataRdy = 1'b1;
      repeat (3) tick();
      WriteDataRdy = 1'b0;
      chk("single_lvl_pre", 32'(Level), 32'd1);
      tick();
      chk("single_lvl_post", 32'(Level), 32'd0);

      // contention: alternating grants starting with requester 1
      Req1Valid = 1'b1; Req1Addr = 19'h00100; Req1Data = 8'h11;
      Req2Valid = 1'b1; Req2Addr = 19'h00200; Req2Data = 8'h22;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("cont_r1", 32'(Req1Ready), (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("cont_r2", 32'(Req2Ready), (i % 2 == 1) ? 32'd1 : 32'd0);
         tick();
      end
      #1;
      chk("cont_full_rdy", 32'({Req1Ready, Req2Ready}), 32'd0);
      chk("cont_level", 32'(Level), 32'd4);
      Req1Valid = 1'b0; Req2Valid = 1'b0;
      retire_one(8'h11);
      retire_one(8'h22);
      retire_one(8'h11);
      retire_one(8'h22);
      Req1Valid = 1'b1; Req2Valid = 1'b1;
      #1;
      chk("prio_end_r1", 32'(Req1Ready), 32'd1);
      chk("prio_end_r2", 32'(Req2Ready), 32'd0);
      tick();
      Req1Valid = 1'b0; Req2Valid = 1'b0;
      tick();
      retire_one(8'h11);
      chk("cont_drained", 32'(Level), 32'd0);

      // full gating: fifth push waits until after the pop edge
      for (int i = 0; i < 4; i++) push1(19'(32'h400 + i), 8'(8'h40 + i));
      Req1Valid = 1'b1; Req1Addr = 19'h00404; Req1Data = 8'h44;
      #1;
      chk("full_ready", 32'(Req1Ready), 32'd0);
      chk("full_level", 32'(Level), 32'd4);
      WriteDataRdy = 1'b1;
      repeat (3) tick();
      WriteDataRdy = 1'b0;
      #1 chk("full_popcyc_rdy", 32'(Req1Ready), 32'd0);
      tick();
      chk("full_after_pop_lvl", 32'(Level), 32'd3);
      chk("full_after_pop_rdy", 32'(Req1Ready), 32'd1);
      tick();
      Req1Valid = 1'b0;
      chk("full_refill_lvl", 32'(Level), 32'd4);
      retire_one(8'h41);
      retire_one(8'h42);
      retire_one(8'h43);
      retire_one(8'h44);
      chk("full_drained", 32'(Level), 32'd0);

      // unowned window: push during a window that opened on an empty FIFO
      WriteDataRdy = 1'b1;
      tick();
      Req1Valid = 1'b1; Req1Addr = 19'h003C0; Req1Data = 8'h3C;
      #1 chk("unown_ready", 32'(Req1Ready), 32'd1);
      tick();
      Req1Valid = 1'b0;
      chk("unown_has_a", 32'(HasWriteData), 32'd0);
      chk("unown_lvl_a", 32'(Level), 32'd1);
      tick();
      chk("unown_has_b", 32'(HasWriteData), 32'd0);
      WriteDataRdy = 1'b0;
      tick();
      chk("unown_lvl_c", 32'(Level), 32'd1);
      chk("unown_has_c", 32'(HasWriteData), 32'd1);
      retire_one(8'h3C);
      chk("unown_drained", 32'(Level), 32'd0);

      // wrap-around over ten single-entry cycles
      for (int i = 0; i < 10; i++) begin
         push1(19'(32'h500 + i), 8'(i));
         tick();
         chk("wrap_addr", 32'(WrAddr), 32'h500 + 32'(i));
         retire_one(8'(i));
      end
      chk("wrap_level", 32'(Level), 32'd0);

      // asynchronous reset in the middle of an owned window
      push1(19'h00060, 8'h60);
      push1(19'h00061, 8'h61);
      push1(19'h00062, 8'h62);
      chk("rstw_level", 32'(Level), 32'd3);
      WriteDataRdy = 1'b1;
      tick();
      tick();
      #2 MemResetN = 1'b0;
      model_reset();
      #1;
      chk("rstw_has",    32'(HasWriteData), 32'd0);
      chk("rstw_wraddr", 32'(WrAddr),       32'd0);
      chk("rstw_wrdata", 32'(WrData),       32'd0);
      chk("rstw_level",  32'(Level),        32'd0);
      MemResetN = 1'b1;
      tick();
      WriteDataRdy = 1'b0;
      tick();
      chk("rstw_lvl_a", 32'(Level), 32'd0);
      chk("rstw_has_a", 32'(HasWriteData), 32'd0);
      tick();
      chk("rstw_lvl_b", 32'(Level), 32'd0);
      chk("rstw_has_b", 32'(HasWriteData), 32'd0);

      cmp_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
